// File: rtl/floating_point_delay_line.sv
// Latency-matching delay line for packed floating point words with a shared valid,
// pipeline enable, synchronous flush, optional zeroing of invalid data and an in-flight count.
module floating_point_delay_line #(
    parameter int EXP_WIDTH    = 8,
    parameter int FRAC_WIDTH   = 23,
    parameter int CHANNELS     = 1,
    parameter int LATENCY      = 7,
    parameter bit ZERO_INVALID = 1'b0,
    localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH,
    localparam int CNT_WIDTH    = $clog2(LATENCY + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             en_i,
    input  logic                             flush_i,
    input  logic [CHANNELS*FP_WIDTH_REG-1:0] fp_i,
    input  logic                             valid_i,
    output logic [CHANNELS*FP_WIDTH_REG-1:0] fp_o,
    output logic                             valid_o,
    output logic [CNT_WIDTH-1:0]             inflight_o
);

    localparam int DATA_W = CHANNELS * FP_WIDTH_REG;

    // Flow control: a beat is accepted only on an edge with en_i=1 and no reset/flush.
    // en_i=0 freezes every stage; the producer must stall alongside, so valid_i is ignored.
    logic [DATA_W-1:0]    data_q [LATENCY];
    logic [LATENCY-1:0]   vld_q;
    logic [CNT_WIDTH-1:0] inflight_q;
    logic [DATA_W-1:0]    stage0_d;
    logic                 advance;

    assign advance  = en_i && !flush_i && !rst_i;
    assign stage0_d = (ZERO_INVALID && !valid_i) ? '0 : fp_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            vld_q      <= '0;
            inflight_q <= '0;
        end else if (en_i) begin
            vld_q[0] <= valid_i;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            // Entry and exit on the same edge cancel, so the count never leaves 0..LATENCY.
            inflight_q <= inflight_q + CNT_WIDTH'(valid_i) - CNT_WIDTH'(vld_q[LATENCY-1]);
        end
    end

    // Data is only cleared in zeroing mode; otherwise stale words simply sit under vld=0.
    always_ff @(posedge clk_i) begin
        if (ZERO_INVALID && (rst_i || flush_i)) begin
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else if (advance) begin
            data_q[0] <= stage0_d;
            for (int i = 1; i < LATENCY; i++) begin
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign fp_o       = data_q[LATENCY-1];
    assign valid_o    = vld_q[LATENCY-1];
    assign inflight_o = inflight_q;

endmodule

// File: tb/tb_floating_point_delay_line.sv
// Bench for floating_point_delay_line: two instances (plain and zeroing mode) share stimulus
// and are compared cycle by cycle against a queue-based model of enabled-edge delay.
module tb_floating_point_delay_line;
  localparam int EW  = 8;
  localparam int FW  = 23;
  localparam int CH  = 2;
  localparam int LAT = 7;
  localparam int W   = 1 + EW + FW;
  localparam int DW  = CH * W;
  localparam int CW  = $clog2(LAT + 1);

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] fp_in = '0;
  logic [DW-1:0] fp_a, fp_z;
  logic          valid_a, valid_z;
  logic [CW-1:0] inflight_a, inflight_z;

  always #5 clk = ~clk;

  floating_point_delay_line #(.EXP_WIDTH(EW), .FRAC_WIDTH(FW), .CHANNELS(CH),
                              .LATENCY(LAT), .ZERO_INVALID(1'b0)) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush), .fp_i(fp_in),
    .valid_i(valid_in), .fp_o(fp_a), .valid_o(valid_a), .inflight_o(inflight_a));

  floating_point_delay_line #(.EXP_WIDTH(EW), .FRAC_WIDTH(FW), .CHANNELS(CH),
                              .LATENCY(LAT), .ZERO_INVALID(1'b1)) dut_z (
    .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush), .fp_i(fp_in),
    .valid_i(valid_in), .fp_o(fp_z), .valid_o(valid_z), .inflight_o(inflight_z));

  // ---------------- reference model ----------------
  // Each queue holds the last LAT accepted beats, newest at the front; the oldest is the output.
  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
  } beat_t;

  beat_t         mq_a[$];
  beat_t         mq_z[$];
  logic [DW-1:0] exp_q[$];
  int            nchk = 0;
  int            nerr = 0;
  int            cyc = 0;
  logic          exp_va, exp_vz;
  logic [DW-1:0] exp_da, exp_dz;
  int            exp_na, exp_nz;

  task automatic refresh_expect();
    exp_va = mq_a[LAT-1].v;
    exp_da = mq_a[LAT-1].d;
    exp_vz = mq_z[LAT-1].v;
    exp_dz = mq_z[LAT-1].d;
    exp_na = 0;
    exp_nz = 0;
    foreach (mq_a[i]) exp_na += int'(mq_a[i].v);
    foreach (mq_z[i]) exp_nz += int'(mq_z[i].v);
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic r, input logic f, input logic e, input logic v,
                       input logic [DW-1:0] d);
    beat_t b;
    rst = r; flush = f; en = e; valid_in = v; fp_in = d;
    @(posedge clk);
    if (r || f) begin
      foreach (mq_a[i]) mq_a[i].v = 1'b0;
      foreach (mq_z[i]) begin
        mq_z[i].v = 1'b0;
        mq_z[i].d = '0;
      end
    end else if (e) begin
      b.v = v; b.d = d;
      mq_a.push_front(b);
      void'(mq_a.pop_back());
      b.d = v ? d : '0;
      mq_z.push_front(b);
      void'(mq_z.pop_back());
    end
    refresh_expect();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    beat_t b;
    b.v = 1'b0; b.d = '0;
    for (int i = 0; i < LAT; i++) begin
      mq_a.push_back(b);
      mq_z.push_back(b);
    end
    cycle(1, 0, 1, 1, rand_word());
    cycle(1, 0, 0, 1, rand_word());
    nchk++;
    if (valid_a !== 1'b0 || inflight_a !== 3'd0) begin
      nerr++;
      $display("FAIL reset_a valid=%b/0 inflight=%0d/0", valid_a, inflight_a);
    end
    nchk++;
    if (valid_z !== 1'b0 || inflight_z !== 3'd0 || fp_z !== '0) begin
      nerr++;
      $display("FAIL reset_z valid=%b/0 inflight=%0d/0 fp=%h/0", valid_z, inflight_z, fp_z);
    end
  endtask

  task automatic test_streaming();
    logic [DW-1:0] word;
    word = {32'h4000_0000, 32'h3F80_0000};
    for (int i = 0; i < LAT + 2; i++) begin
      cycle(0, 0, 1, (i == 0), (i == 0) ? word : rand_word());
      nchk++;
      if (valid_a !== (i == LAT - 1) || inflight_a !== CW'((i < LAT) ? 1 : 0)) begin
        nerr++;
        $display("FAIL stream_a i=%0d valid=%b/%b inflight=%0d/%0d", i, valid_a,
                 (i == LAT - 1), inflight_a, (i < LAT) ? 1 : 0);
      end
      if (i == LAT - 1) begin
        nchk++;
        if (fp_a !== word || fp_z !== word) begin
          nerr++;
          $display("FAIL stream_data fp_a=%h fp_z=%h exp=%h", fp_a, fp_z, word);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] w;
    logic [DW-1:0] exp_w;
    int            first_seen;
    int            t;
    first_seen = -1;
    t = 0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      w = rand_word();
      exp_q.push_back(w);
      cycle(0, 0, 1, 1, w);
      t++;
    end
    cycle(0, 0, 1, 0, rand_word());
    t++;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 1'($urandom_range(0, 1)), rand_word());
      t++;
      nchk++;
      if (valid_a !== 1'b0 || inflight_a !== 3'd3 || inflight_z !== 3'd3) begin
        nerr++;
        $display("FAIL stall_hold i=%0d valid=%b/0 inflight_a=%0d inflight_z=%0d exp=3",
                 i, valid_a, inflight_a, inflight_z);
      end
    end
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 1, 0, rand_word());
      if (valid_a === 1'b1) begin
        if (first_seen < 0) first_seen = t;
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        nchk++;
        if (fp_a !== exp_w) begin
          nerr++;
          $display("FAIL stall_order fp=%h exp=%h", fp_a, exp_w);
        end
      end
      t++;
    end
    nchk++;
    if (first_seen != LAT - 1 + 4 || exp_q.size() != 0) begin
      nerr++;
      $display("FAIL stall_latency first=%0d exp=%0d left=%0d exp=0", first_seen, LAT + 3,
               exp_q.size());
    end
  endtask

  task automatic test_flush();
    logic [DW-1:0] d_word;
    d_word = rand_word();
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 1, rand_word());
    nchk++;
    if (inflight_a !== 3'd5) begin
      nerr++;
      $display("FAIL flush_pre inflight=%0d exp=5", inflight_a);
    end
    cycle(0, 1, 1, 1, d_word);
    nchk++;
    if (inflight_a !== 3'd0 || inflight_z !== 3'd0 || valid_a !== 1'b0 || fp_z !== '0) begin
      nerr++;
      $display("FAIL flush_kill inflight=%0d/%0d valid=%b fp_z=%h exp 0",
               inflight_a, inflight_z, valid_a, fp_z);
    end
    for (int i = 0; i < LAT; i++) begin
      cycle(0, 0, 1, 0, rand_word());
      nchk++;
      if (valid_a !== 1'b0 || valid_z !== 1'b0 || inflight_a !== 3'd0) begin
        nerr++;
        $display("FAIL flush_after i=%0d valid=%b/%b inflight=%0d exp 0", i, valid_a, valid_z,
                 inflight_a);
      end
    end
  endtask

  task automatic test_zero_mode();
    logic [DW-1:0] ones;
    ones = '1;
    for (int i = 0; i < 2 * LAT + 4; i++) begin
      cycle(0, 0, 1, 1'(i % 2 == 0), ones);
      if (i >= LAT - 1) begin
        nchk++;
        if (valid_z !== 1'((i - (LAT - 1)) % 2 == 0) || fp_z !== (valid_z ? ones : '0)) begin
          nerr++;
          $display("FAIL zero_mode i=%0d valid=%b fp=%h", i, valid_z, fp_z);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 1, 1, rand_word());
      nchk++;
      if (inflight_a !== exp_na[CW-1:0] || exp_na > LAT ||
          (i >= LAT - 1 && inflight_a !== 3'd7) || (valid_a && fp_a !== exp_da)) begin
        nerr++;
        $display("FAIL full_pipe i=%0d inflight=%0d/%0d fp=%h/%h", i, inflight_a, exp_na,
                 fp_a, exp_da);
      end
    end
    for (int i = 0; i < LAT; i++) begin
      cycle(0, 0, 1, 0, rand_word());
      nchk++;
      if (inflight_a !== CW'(LAT - 1 - i) || inflight_z !== CW'(LAT - 1 - i)) begin
        nerr++;
        $display("FAIL drain i=%0d inflight=%0d/%0d exp=%0d", i, inflight_a, inflight_z,
                 LAT - 1 - i);
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1, rand_word());
    cycle(0, 0, 0, 1, rand_word());
    cycle(1, 0, 0, 1, rand_word());
    nchk++;
    if (valid_a !== 1'b0 || inflight_a !== 3'd0 || inflight_z !== 3'd0 || fp_z !== '0) begin
      nerr++;
      $display("FAIL reset_mid valid=%b inflight=%0d/%0d fp_z=%h exp 0", valid_a, inflight_a,
               inflight_z, fp_z);
    end
    for (int i = 0; i < LAT + 2; i++) begin
      cycle(0, 0, 1, 0, rand_word());
      nchk++;
      if (valid_a !== 1'b0 || valid_z !== 1'b0) begin
        nerr++;
        $display("FAIL reset_stale i=%0d valid=%b/%b exp 0", i, valid_a, valid_z);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 31) == 0),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rand_word());
      nchk++;
      if (valid_a !== exp_va || inflight_a !== exp_na[CW-1:0] || (exp_va && fp_a !== exp_da)) begin
        nerr++;
        $display("FAIL random_a cyc=%0d valid=%b/%b inflight=%0d/%0d fp=%h/%h", cyc, valid_a,
                 exp_va, inflight_a, exp_na, fp_a, exp_da);
      end
      nchk++;
      if (valid_z !== exp_vz || inflight_z !== exp_nz[CW-1:0] || fp_z !== exp_dz) begin
        nerr++;
        $display("FAIL random_z cyc=%0d valid=%b/%b inflight=%0d/%0d fp=%h/%h", cyc, valid_z,
                 exp_vz, inflight_z, exp_nz, fp_z, exp_dz);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_zero_mode();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/floating_point_delay_line.md
Name: floating_point_delay_line

Overview:
- Parametrised latency-matching buffer for floating point streams.
- Delays CHANNELS packed FP words plus one shared valid by a configurable number of stages (LATENCY).
- Adds a pipeline clock-enable (stall) path, a synchronous flush, optional zeroing of invalid data, and an in-flight counter.
- Sits beside floating point arithmetic units to keep side streams aligned with their results, including when the downstream pipeline stalls.

Parameters:
- EXP_WIDTH, 8, exponent field width.
- FRAC_WIDTH, 23, fraction field width.
- CHANNELS, 1, number of independent FP words carried per beat (>=1).
- LATENCY, 7, number of register stages (>=1); default matches the adder pipeline depth.
- ZERO_INVALID, 0, 1 = a stage captures all-zero data when its incoming valid is 0.
- FP_WIDTH_REG, 1+EXP_WIDTH+FRAC_WIDTH, local: width of one FP word.
- CNT_WIDTH, $clog2(LATENCY+1), local: in-flight counter width.

Ports:
- clk_i  in  1  clock; all logic on posedge.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  1  pipeline advance; 0 = hold every stage.
- flush_i  in  1  synchronous flush; kills all in-flight beats.
- fp_i  in  CHANNELS*FP_WIDTH_REG  packed input words; channel k at bits [k*FP_WIDTH_REG +: FP_WIDTH_REG].
- valid_i  in  1  input beat valid.
- fp_o  out  CHANNELS*FP_WIDTH_REG  packed delayed words, same packing.
- valid_o  out  1  delayed valid.
- inflight_o  out  CNT_WIDTH  number of valid beats currently held in the stages.

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Storage: stage arrays data[0..LATENCY-1] and vld[0..LATENCY-1].
- Outputs: fp_o = data[LATENCY-1]; valid_o = vld[LATENCY-1]; both are registered and have no combinational path from the inputs.
- Reset (rst_i=1): all vld cleared and inflight_o = 0 on the next edge.
  - Data registers are not reset, except when ZERO_INVALID=1: data then resets to 0, so fp_o = 0 after reset.
  - valid_o = 0 after reset.
- Priority at each edge: rst_i > flush_i > en_i.
- flush_i=1 (rst_i=0): all vld cleared and inflight_o <= 0.
  - Data is unchanged when ZERO_INVALID=0 and cleared when ZERO_INVALID=1.
  - valid_i presented in a flush cycle is dropped regardless of en_i.
- en_i=1 (no rst, no flush): shift by one stage.
  - vld[0] <= valid_i; data[0] <= fp_i, or 0 if ZERO_INVALID=1 and valid_i=0.
  - Stage i <= stage i-1 for i >= 1.
- en_i=0: every stage holds; fp_o and valid_o remain stable; valid_i and fp_i are ignored (the producer must also stall).
- Latency: with en_i held at 1, a beat presented at edge N appears on the outputs after edge N+LATENCY-1, i.e. LATENCY cycles later.
  - With stalls, the latency equals LATENCY enabled edges.
- inflight_o is a registered counter and always equals popcount(vld[]).
  - Update only when en_i=1: next = cur + valid_i - vld[LATENCY-1].
  - Simultaneous entry and exit leaves it unchanged.
  - Range is 0..LATENCY; it cannot wrap by construction.
- Channels share valid, enable and flush; no cross-channel interaction.
- LATENCY=1 degenerates to a single enabled register with the same rules.

Test Plan:
- Reset and streaming: rst_i=1 for 2 cycles → valid_o=0, inflight_o=0. Then with LATENCY=7, CHANNELS=2, en_i=1, drive valid_i=1 with fp_i ch0=0x3F800000, ch1=0x40000000 at cycle 0 → valid_o=1 and fp_o equal to the same words at cycle 7, valid_o=0 at cycles 1–6, inflight_o=1 from cycle 1 to 7.
- Stall: send 3 back-to-back beats A,B,C, then drop en_i for 4 cycles starting when A sits in stage 3 → outputs frozen and inflight_o=3 throughout the stall. Beats then emerge in order A,B,C, each 4 cycles later than with no stall.
- Flush: with 5 beats in flight, assert flush_i=1 together with en_i=1 and valid_i=1 (beat D) → next cycle inflight_o=0, valid_o=0 for the following 7 cycles, and D never appears.
- Zero mode: ZERO_INVALID=1, alternate valid_i 1/0 with fp_i=0xFFFFFFFF → fp_o alternates between 0xFFFFFFFF and 0x00000000 in lockstep with valid_o.
- Full pipe with simultaneous in/out: continuous valid_i=1 for 20 cycles → inflight_o saturates at 7 and stays there with no overflow. Then stop valid_i → inflight_o decrements 7→0 over 7 cycles.
- Reset mid-stream: rst_i=1 while stalled (en_i=0) with 4 beats in flight → next cycle valid_o=0 and inflight_o=0, and no stale beat emerges after release.
